term_vram_ctrl: RTL and testbench
=================================

Name: term_vram_ctrl

Overview:
Sequences all writes into the 80x30 character buffer (port A) from a byte stream, normally received UART characters.
- Maintains the cursor and handles CR, LF, BS and FF.
- Swallows ANSI ESC[...] sequences, so the prompt's ESC[31m and ESC[0m never reach the screen.
- Performs line and screen clears.
- Runs circular scrolling and exports top_row, which the display adds to sy[8:4] when forming the read address.

Parameters:
- COLS, 80, characters per row
- ROWS, 30, rows in buffer
- COL_W, 7, column index width
- ROW_W, 5, row index width
- ADDR_W, 12, VRAM address width; address = {row, col}
- CSI_MAX, 16, maximum bytes in one CSI sequence before abort

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- in_data  in  8  input byte
- in_valid  in  1  byte present
- in_ready  out  1  byte accepted when in_valid && in_ready
- vram_addr  out  ADDR_W  write address {row, col}
- vram_data  out  8  write data
- vram_we  out  1  write strobe, one write per cycle
- cursor_col  out  COL_W  current column
- cursor_row  out  ROW_W  current physical row
- top_row  out  ROW_W  physical row shown at the top of the screen
- busy  out  1  clear sweep in progress

Behaviour:
- Reset (async, asserted): state IDLE; vram_we=0; vram_addr=0; vram_data=0; cursor (0,0); top_row=0; full=0; busy=0. in_ready = !rst && state in {IDLE, ESC, CSI}.
- All outputs except in_ready are registered. A byte accepted at cycle N updates vram_* and the cursor at N+1. Throughput is 1 byte/cycle in IDLE.
- Printable 0x20-0x7E:
  - Write to {row, col}.
  - If col<COLS-1: col++.
  - Else: col=0, then line-advance.
- CR 0x0D or 0x8D: col=0, no write.
- LF 0x0A: line-advance; col unchanged.
- BS 0x08:
  - col>0: col--, write 0x20 at the new col.
  - col=0: no write, no change.
- FF 0x0C: clear screen.
- ESC 0x1B: go to ESC. Other bytes 0x00-0x1F and 0x7F-0xFF not listed above: ignored, no write.
- Line-advance:
  - r_next = (row+1) mod ROWS.
  - If full=0 and row<ROWS-1: row=r_next, no clear.
  - Otherwise:
    - row=r_next; full=1.
    - top_row = (r_next+1) mod ROWS.
    - Enter CLR_LINE for row r_next.
- States:
  - IDLE: accept bytes.
  - ESC:
    - Next byte '[' goes to CSI; csi_cnt=0, param=0.
    - Any other byte is discarded; return to IDLE.
  - CSI:
    - Bytes 0x30-0x3F (digits, ';'): consumed, csi_cnt++.
    - Digits accumulate in param; modulo 256 is acceptable.
    - Final byte 0x40-0x7E ends the sequence. 'J' clears the screen regardless of parameter; every other final byte ('m', 'H', ...) is a no-op. Return to IDLE.
    - Any other byte, or csi_cnt reaching CSI_MAX: abort to IDLE; that byte is discarded.
    - No VRAM write ever occurs in ESC or CSI.
  - CLR_LINE:
    - in_ready=0, busy=1.
    - COLS consecutive cycles with vram_we=1, data 0x20, addr {r_next, 0..COLS-1}.
    - Then IDLE.
  - CLR_SCREEN:
    - in_ready=0, busy=1.
    - ROWS*COLS cycles, rows 0..ROWS-1, cols 0..COLS-1, data 0x20.
    - Cursor (0,0), top_row=0, full=0 are set on entry.
    - Then IDLE.
- vram_we is never asserted for column indices >= COLS.
- Reset mid-sweep aborts immediately; no completion.

Decomposition:
- Package term_pkg:
  - COLS, ROWS and the widths.
  - Character codes CHR_CR, CHR_CR_HI (0x8D), CHR_LF, CHR_BS, CHR_FF, CHR_ESC, CHR_SPACE, CHR_LBRACKET.
  - State enum: IDLE, ESC, CSI, CLR_LINE, CLR_SCREEN.
- Sub-module term_clear_seq: row/column sweep counter.
  - Inputs: start, single_row, row.
  - Outputs: addr, we, done.
  - Shared by CLR_LINE and CLR_SCREEN.

Test Plan:
1. Reset, send 0x41 -> next cycle vram_we=1, addr 0x000, data 0x41; cursor_col=1; no other writes.
2. Send 80x 0x55 then 0x42 -> 80th write at 0x04F; 0x42 written at 0x080; cursor (row 1, col 1).
3. Move to col 5, send 0x08 -> write 0x20 at 0x004, cursor_col=4. At col 0, send 0x08 -> no write, cursor unchanged.
4. Send 1B 5B 33 31 6D 58 -> exactly one write: 0x58 at the current cursor. Then send 1B 5B 32 4A -> busy for 2400 cycles, 2400 writes of 0x20 covering 0x000-0x04F through {29,79}, cursor (0,0), top_row 0.
5. From (0,0) send 29x LF -> row 29, no writes. 30th LF -> row 0, top_row=1, 80 writes of 0x20 at 0x000-0x04F, in_ready low for 80 cycles. 31st LF -> row 1, top_row=2, row 1 cleared.
6. Assert rst at cycle 100 of a clear-screen sweep -> vram_we=0 and busy=0 immediately. After release, send 0x41 -> written at 0x000.

Source files
------------

// File: rtl/term_pkg.sv
// term_pkg: geometry, character codes and controller states shared by the VRAM write path.
package term_pkg;
  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int COL_W = 7;
  localparam int ROW_W = 5;
  localparam int ADDR_W = 12;
  localparam int CSI_MAX = 16;
  localparam logic [7:0] CHR_CR = 8'h0D;
  localparam logic [7:0] CHR_CR_HI = 8'h8D;
  localparam logic [7:0] CHR_LF = 8'h0A;
  localparam logic [7:0] CHR_BS = 8'h08;
  localparam logic [7:0] CHR_FF = 8'h0C;
  localparam logic [7:0] CHR_ESC = 8'h1B;
  localparam logic [7:0] CHR_SPACE = 8'h20;
  localparam logic [7:0] CHR_LBRACKET = 8'h5B;
  typedef enum logic [2:0] {IDLE, ESC, CSI, CLR_LINE, CLR_SCREEN} state_e;
endpackage

// File: rtl/term_clear_seq.sv
// term_clear_seq: sweeps one row or the whole buffer, one address per cycle, for space fills.
module term_clear_seq
  import term_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              single_row_i,
  input  logic [ROW_W-1:0]  row_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              we_o,
  output logic              done_o
);
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  logic single_q, act_q, last_col;
  assign last_col = col_q == COL_W'(COLS - 1);
  assign done_o = act_q && last_col && (single_q || row_q == ROW_W'(ROWS - 1));
  assign addr_o = {row_q, col_q};
  assign we_o = act_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q <= 1'b0;
      single_q <= 1'b0;
      row_q <= '0;
      col_q <= '0;
    end else if (start_i) begin
      act_q <= 1'b1;
      single_q <= single_row_i;
      row_q <= single_row_i ? row_i : '0;
      col_q <= '0;
    end else if (act_q) begin
      act_q <= !done_o;
      col_q <= last_col ? '0 : col_q + 1'b1;
      row_q <= last_col ? row_q + 1'b1 : row_q;
    end
  end
endmodule

// File: rtl/term_vram_ctrl.sv
// term_vram_ctrl: turns a byte stream into character VRAM writes with cursor, ANSI CSI
// swallowing, line/screen clears and circular scrolling via top_row.
module term_vram_ctrl
  import term_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_data,
  output logic              vram_we,
  output logic [COL_W-1:0]  cursor_col,
  output logic [ROW_W-1:0]  cursor_row,
  output logic [ROW_W-1:0]  top_row,
  output logic              busy
);
  state_e state_q;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q, top_q, r_next, top_next;
  logic full_q, we_q, pend_q;
  logic [ADDR_W-1:0] addr_q, seq_addr;
  logic [7:0] data_q, param_q;
  logic [4:0] csi_cnt_q;
  logic accept, idle_acc, printable, is_param, last_col, last_row, adv, wrap_clr, wr;
  logic go_line, go_screen, seq_start, seq_we, seq_done;
  assign in_ready = !rst && (state_q == IDLE || state_q == ESC || state_q == CSI);
  assign accept = in_valid && in_ready;
  assign idle_acc = accept && state_q == IDLE;
  assign printable = in_data >= 8'h20 && in_data <= 8'h7E;
  assign is_param = in_data >= 8'h30 && in_data <= 8'h3F;
  assign last_col = col_q == COL_W'(COLS - 1);
  assign last_row = row_q == ROW_W'(ROWS - 1);
  assign r_next = last_row ? '0 : row_q + 1'b1;
  assign top_next = r_next == ROW_W'(ROWS - 1) ? '0 : r_next + 1'b1;
  assign adv = (printable && last_col) || in_data == CHR_LF;
  assign wrap_clr = adv && (full_q || last_row);
  assign wr = idle_acc && (printable || (in_data == CHR_BS && col_q != '0));
  assign go_line = idle_acc && wrap_clr;
  assign go_screen = (idle_acc && in_data == CHR_FF) || (accept && state_q == CSI && in_data == 8'h4A);
  // a character written in the last column delays its row clear by one cycle (pend_q)
  assign seq_start = (go_line && !wr) || go_screen || pend_q;
  term_clear_seq u_clr (
    .clk          (clk),
    .rst          (rst),
    .start_i      (seq_start),
    .single_row_i (!go_screen),
    .row_i        (pend_q ? row_q : r_next),
    .addr_o       (seq_addr),
    .we_o         (seq_we),
    .done_o       (seq_done)
  );
  assign vram_we = we_q || seq_we;
  assign vram_addr = seq_we ? seq_addr : addr_q;
  assign vram_data = seq_we ? CHR_SPACE : data_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;
  assign top_row = top_q;
  assign busy = state_q == CLR_LINE || state_q == CLR_SCREEN;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      col_q <= '0;
      row_q <= '0;
      top_q <= '0;
      full_q <= 1'b0;
      we_q <= 1'b0;
      pend_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      param_q <= '0;
      csi_cnt_q <= '0;
    end else begin
      we_q <= wr;
      pend_q <= go_line && wr;
      if (wr) begin
        addr_q <= {row_q, printable ? col_q : col_q - 1'b1};
        data_q <= printable ? in_data : CHR_SPACE;
      end
      case (state_q)
        IDLE: if (accept) begin
          if (printable) col_q <= last_col ? '0 : col_q + 1'b1;
          else if (in_data == CHR_CR || in_data == CHR_CR_HI) col_q <= '0;
          else if (in_data == CHR_BS && col_q != '0) col_q <= col_q - 1'b1;
          else if (in_data == CHR_ESC) state_q <= ESC;
          if (adv) row_q <= r_next;
          if (wrap_clr) begin
            full_q <= 1'b1;
            top_q <= top_next;
            state_q <= CLR_LINE;
          end
        end
        ESC: if (accept) begin
          state_q <= in_data == CHR_LBRACKET ? CSI : IDLE;
          csi_cnt_q <= '0;
          param_q <= '0;
        end
        CSI: if (accept) begin
          if (is_param && csi_cnt_q != 5'(CSI_MAX)) begin
            csi_cnt_q <= csi_cnt_q + 1'b1;
            if (in_data <= 8'h39) param_q <= param_q * 8'd10 + (in_data - 8'h30);
          end else state_q <= IDLE;
        end
        default: if (seq_done) state_q <= IDLE;
      endcase
      if (go_screen) begin
        state_q <= CLR_SCREEN;
        col_q <= '0;
        row_q <= '0;
        top_q <= '0;
        full_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_term_vram_ctrl.sv
// tb_term_vram_ctrl: directed and random byte streams checked against a terminal-level model.
module tb_term_vram_ctrl;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, vram_we, busy;
  logic [7:0] in_data = 8'h00, vram_data;
  logic [11:0] vram_addr;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row, top_row;
  int n_checks = 0, n_fail = 0;
  int m_col, m_row, m_top, m_mode, m_cnt, m_full;
  int last_cyc, last_busy;
  logic [19:0] exp_q[$], obs_q[$];
  logic [7:0] seq_a [6] = '{8'h1B, 8'h5B, 8'h33, 8'h31, 8'h6D, 8'h58};
  logic [7:0] seq_b [4] = '{8'h1B, 8'h5B, 8'h32, 8'h4A};
  logic [7:0] finals [6] = '{8'h6D, 8'h48, 8'h4B, 8'h41, 8'h40, 8'h7E};

  term_vram_ctrl dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .vram_addr(vram_addr), .vram_data(vram_data), .vram_we(vram_we),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .top_row(top_row), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void put(input int r, input int c, input int d);
    exp_q.push_back({12'(r * 128 + c), 8'(d)});
  endfunction

  function automatic void clear_screen();
    m_col = 0; m_row = 0; m_top = 0; m_full = 0;
    for (int r = 0; r < 30; r++) for (int c = 0; c < 80; c++) put(r, c, 8'h20);
  endfunction

  function automatic void advance();
    int rn = (m_row + 1) % 30;
    if (m_full == 0 && m_row < 29) m_row = rn;
    else begin
      m_row = rn; m_full = 1; m_top = (rn + 1) % 30;
      for (int c = 0; c < 80; c++) put(rn, c, 8'h20);
    end
  endfunction

  function automatic void model_reset();
    m_col = 0; m_row = 0; m_top = 0; m_full = 0; m_mode = 0; m_cnt = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (m_mode == 1) begin
      m_mode = (b == 8'h5B) ? 2 : 0;
      m_cnt = 0;
    end else if (m_mode == 2) begin
      if (b >= 8'h30 && b <= 8'h3F) begin
        if (m_cnt == 16) m_mode = 0; else m_cnt++;
      end else begin
        if (b == 8'h4A) clear_screen();
        m_mode = 0;
      end
    end else if (b >= 8'h20 && b <= 8'h7E) begin
      put(m_row, m_col, b);
      if (m_col < 79) m_col++; else begin m_col = 0; advance(); end
    end else if (b == 8'h0D || b == 8'h8D) m_col = 0;
    else if (b == 8'h0A) advance();
    else if (b == 8'h08) begin
      if (m_col > 0) begin m_col--; put(m_row, m_col, 8'h20); end
    end else if (b == 8'h0C) clear_screen();
    else if (b == 8'h1B) m_mode = 1;
  endfunction

  // drives one byte at a negedge and gathers every write until the DUT accepts again
  task automatic send(input logic [7:0] b);
    int mi = -1;
    exp_q.delete();
    obs_q.delete();
    model_byte(b);
    in_data = b;
    in_valid = 1'b1;
    chk("ready_before", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    last_cyc = 0;
    last_busy = 0;
    do begin
      @(negedge clk);
      last_cyc++;
      if (vram_we) obs_q.push_back({vram_addr, vram_data});
      if (busy) last_busy++;
    end while (!in_ready && last_cyc < 3000);
    chk("settle", in_ready, 1);
    chk("n_writes", obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (mi < 0 && obs_q[i] !== exp_q[i]) mi = i;
    chk("write_seq_first_bad", mi, -1);
    chk("cursor_col", cursor_col, m_col);
    chk("cursor_row", cursor_row, m_row);
    chk("top_row", top_row, m_top);
  endtask

  task automatic rand_item();
    int k = $urandom_range(0, 199);
    if (k < 100) send(8'($urandom_range(8'h20, 8'h7E)));
    else if (k < 125) send(8'h0A);
    else if (k < 135) send($urandom_range(0, 1) ? 8'h0D : 8'h8D);
    else if (k < 155) send(8'h08);
    else if (k < 156) send(8'h0C);
    else if (k < 180) begin
      send(8'h1B);
      if ($urandom_range(0, 3) == 0) send(8'($urandom_range(0, 255)));
      else begin
        send(8'h5B);
        repeat ($urandom_range(0, 4)) send(8'(8'h30 + $urandom_range(0, 11)));
        k = $urandom_range(0, 19);
        if (k == 0) send(8'h4A);
        else if (k < 3) send(8'h0A);
        else send(finals[$urandom_range(0, 5)]);
      end
    end else send(8'($urandom_range(0, 255)));
  endtask

  initial begin
    int wsum;
    repeat (3) @(negedge clk);
    chk("rst_we", vram_we, 0);
    chk("rst_addr", vram_addr, 0);
    chk("rst_data", vram_data, 0);
    chk("rst_col", cursor_col, 0);
    chk("rst_row", cursor_row, 0);
    chk("rst_top", top_row, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 0);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    send(8'h41);
    chk("t1_nwr", obs_q.size(), 1);
    chk("t1_col", cursor_col, 1);
    send(8'h0D);
    repeat (80) send(8'h55);
    chk("t2_wrap_row", cursor_row, 1);
    send(8'h42);
    chk("t2_col", cursor_col, 1);
    chk("t2_row", cursor_row, 1);
    send(8'h0D);
    repeat (5) send(8'h61);
    send(8'h08);
    chk("t3_bs_col", cursor_col, 4);
    chk("t3_bs_nwr", obs_q.size(), 1);
    send(8'h0D);
    send(8'h08);
    chk("t3_bs0_nwr", obs_q.size(), 0);
    chk("t3_bs0_col", cursor_col, 0);
    wsum = 0;
    foreach (seq_a[i]) begin send(seq_a[i]); wsum += obs_q.size(); end
    chk("t4_csi_writes", wsum, 1);
    foreach (seq_b[i]) send(seq_b[i]);
    chk("t4_clr_busy", last_busy, 2400);
    chk("t4_clr_nwr", obs_q.size(), 2400);
    repeat (29) send(8'h0A);
    chk("t5_row29", cursor_row, 29);
    send(8'h0A);
    chk("t5_scroll_row", cursor_row, 0);
    chk("t5_scroll_top", top_row, 1);
    chk("t5_ready_low", last_cyc - 1, 80);
    chk("t5_busy", last_busy, 80);
    send(8'h0A);
    chk("t5_top2", top_row, 2);
    in_data = 8'h0C;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (100) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_we", vram_we, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    send(8'h41);
    chk("t6_addr", vram_addr, 0);
    repeat (500) rand_item();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
